// File: rtl/index_address_unit.sv
// Indexed effective-address generator for the 65C02 abs,Y / zp,Y / (zp),Y modes.
// Collects operand and pointer bytes from the data bus, adds the index, and runs a fix-up cycle on page carry.
module index_address_unit #(
  parameter logic [7:0] ZP_PAGE = 8'h00
) (
  input  logic        fclk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [7:0]  index_in,
  input  logic [7:0]  db_in,
  input  logic        db_valid,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic        busy,
  output logic [15:0] ea,
  output logic        ea_valid,
  output logic        page_cross
);

  typedef enum logic [2:0] {
    IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, ADD, FIX, DONE
  } state_t;

  localparam logic [1:0] M_ABS_Y  = 2'b00;
  localparam logic [1:0] M_ZP_Y   = 2'b01;
  localparam logic [1:0] M_IND_Y  = 2'b10;
  localparam logic [1:0] M_ABS_YF = 2'b11;

  state_t     state, state_nx;
  logic [1:0] mode_r;
  logic [7:0] index_r;
  logic [7:0] zp_r;
  logic [7:0] base_lo;
  logic [7:0] base_hi;
  logic       carry_r;
  logic [8:0] sum;

  // 9-bit low-byte add; bit 8 is the page-cross carry.
  function automatic logic [8:0] add_carry(input logic [7:0] a, input logic [7:0] b);
    add_carry = {1'b0, a} + {1'b0, b};
  endfunction

  assign sum = add_carry(base_lo, index_r);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = OP_LO;
      OP_LO:  if (db_valid) begin
                case (mode_r)
                  M_ZP_Y:  state_nx = ADD;
                  M_IND_Y: state_nx = PTR_LO;
                  default: state_nx = OP_HI;
                endcase
              end
      OP_HI:  if (db_valid) state_nx = ADD;
      PTR_LO: if (db_valid) state_nx = PTR_HI;
      PTR_HI: if (db_valid) state_nx = ADD;
      ADD:    begin
                if (mode_r == M_ZP_Y)                       state_nx = DONE;
                else if (sum[8] || (mode_r == M_ABS_YF))    state_nx = FIX;
                else                                        state_nx = DONE;
              end
      FIX:    state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    ea_valid = (state == DONE);
    mem_rd   = 1'b0;
    mem_addr = 16'h0000;
    if (state == PTR_LO) begin
      mem_rd   = 1'b1;
      mem_addr = {ZP_PAGE, zp_r};
    end else if (state == PTR_HI) begin
      mem_rd   = 1'b1;
      mem_addr = {ZP_PAGE, zp_r + 8'h01};  // pointer high byte wraps inside the page
    end
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      state      <= IDLE;
      mode_r     <= M_ABS_Y;
      index_r    <= 8'h00;
      zp_r       <= 8'h00;
      base_lo    <= 8'h00;
      base_hi    <= 8'h00;
      carry_r    <= 1'b0;
      ea         <= 16'h0000;
      page_cross <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          mode_r     <= mode;
          index_r    <= index_in;
          page_cross <= 1'b0;
        end
        OP_LO: if (db_valid) begin
          zp_r    <= db_in;
          base_lo <= db_in;
          base_hi <= ZP_PAGE;
        end
        OP_HI:  if (db_valid) base_hi <= db_in;
        PTR_LO: if (db_valid) base_lo <= db_in;
        PTR_HI: if (db_valid) base_hi <= db_in;
        ADD: begin
          if (mode_r == M_ZP_Y) begin
            ea         <= {ZP_PAGE, sum[7:0]};
            page_cross <= 1'b0;
            carry_r    <= 1'b0;
          end else begin
            ea         <= {base_hi, sum[7:0]};
            page_cross <= sum[8];
            carry_r    <= sum[8];
          end
        end
        FIX: ea[15:8] <= base_hi + {7'd0, carry_r};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_index_address_unit.sv
// Directed bench for index_address_unit: reset abort, abs,Y, zp,Y, (zp),Y, forced fix and ignore rules.
module tb_index_address_unit;

  logic        fclk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  index_in = 8'h00;
  logic [7:0]  db_in = 8'h00;
  logic        db_valid = 1'b0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        busy;
  logic [15:0] ea;
  logic        ea_valid;
  logic        page_cross;

  int n_checks = 0;
  int n_fail = 0;

  index_address_unit #(.ZP_PAGE(8'h00)) dut (
    .fclk(fclk), .reset(reset), .start(start), .mode(mode), .index_in(index_in),
    .db_in(db_in), .db_valid(db_valid), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .busy(busy), .ea(ea), .ea_valid(ea_valid), .page_cross(page_cross)
  );

  always #5 fclk = ~fclk;

  task automatic tick;
    @(posedge fclk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [7:0] idx);
    start = 1'b1; mode = m; index_in = idx;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b);
    db_valid = 1'b1; db_in = b;
    tick();
    db_valid = 1'b0;
  endtask

  // Called right after the last byte is accepted; n counts cycles since that byte.
  task automatic wait_ea(output int n);
    n = 1;
    while (ea_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    int pulses;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (ea !== 16'h0000) begin n_fail++; $display("FAIL reset_ea: got %h expected 0000", ea); end
    n_checks++; if ({ea_valid, page_cross, mem_rd} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {ea_valid, page_cross, mem_rd}); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    reset = 1'b0;
    tick();
    do_start(2'b00, 8'h05);
    feed(8'h10);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_abort_busy: got %b expected 1", busy); end
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (ea !== 16'h0000) begin n_fail++; $display("FAIL abort_ea: got %h expected 0000", ea); end
    pulses = 0;
    db_valid = 1'b1; db_in = 8'h20;
    for (int i = 0; i < 5; i++) begin
      if (ea_valid === 1'b1 || busy === 1'b1) pulses++;
      tick();
    end
    db_valid = 1'b0;
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", pulses); end
  endtask

  task automatic test_abs_no_cross;
    int n;
    do_start(2'b00, 8'h05);
    feed(8'h10);
    feed(8'h20);
    wait_ea(n);
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL abs_latency: got %0d expected 2", n); end
    n_checks++; if (ea !== 16'h2015) begin n_fail++; $display("FAIL abs_ea: got %h expected 2015", ea); end
    n_checks++; if (page_cross !== 1'b0) begin n_fail++; $display("FAIL abs_pc: got %b expected 0", page_cross); end
    tick();
    n_checks++; if ({ea_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL abs_after: got %b expected 00", {ea_valid, busy}); end
    n_checks++; if (ea !== 16'h2015) begin n_fail++; $display("FAIL abs_hold: got %h expected 2015", ea); end
  endtask

  task automatic test_abs_cross;
    int n;
    do_start(2'b00, 8'h10);
    feed(8'hF8);
    feed(8'h12);
    wait_ea(n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL cross_latency: got %0d expected 3", n); end
    n_checks++; if (ea !== 16'h1308) begin n_fail++; $display("FAIL cross_ea: got %h expected 1308", ea); end
    n_checks++; if (page_cross !== 1'b1) begin n_fail++; $display("FAIL cross_pc: got %b expected 1", page_cross); end
    tick();
    do_start(2'b00, 8'h10);
    feed(8'hF8);
    feed(8'hFF);
    wait_ea(n);
    n_checks++; if (ea !== 16'h0008) begin n_fail++; $display("FAIL wrap_ea: got %h expected 0008", ea); end
    n_checks++; if (page_cross !== 1'b1) begin n_fail++; $display("FAIL wrap_pc: got %b expected 1", page_cross); end
    tick();
  endtask

  task automatic test_zp_wrap;
    int n;
    do_start(2'b01, 8'h20);
    feed(8'hF0);
    wait_ea(n);
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL zp_latency: got %0d expected 2", n); end
    n_checks++; if (ea !== 16'h0010) begin n_fail++; $display("FAIL zp_ea: got %h expected 0010", ea); end
    n_checks++; if (page_cross !== 1'b0) begin n_fail++; $display("FAIL zp_pc: got %b expected 0", page_cross); end
    tick();
  endtask

  task automatic test_ind_y;
    int n;
    do_start(2'b10, 8'h01);
    feed(8'hFF);
    n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 16'h00FF}) begin n_fail++; $display("FAIL ptr_lo: got %b/%h expected 1/00ff", mem_rd, mem_addr); end
    tick();
    n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 16'h00FF}) begin n_fail++; $display("FAIL ptr_lo_wait: got %b/%h expected 1/00ff", mem_rd, mem_addr); end
    feed(8'hFF);
    n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL ptr_hi: got %b/%h expected 1/0000", mem_rd, mem_addr); end
    feed(8'h30);
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL ptr_rd_off: got %b expected 0", mem_rd); end
    wait_ea(n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL ind_latency: got %0d expected 3", n); end
    n_checks++; if (ea !== 16'h3100) begin n_fail++; $display("FAIL ind_ea: got %h expected 3100", ea); end
    n_checks++; if (page_cross !== 1'b1) begin n_fail++; $display("FAIL ind_pc: got %b expected 1", page_cross); end
    tick();
  endtask

  task automatic test_forced_fix;
    int busy_cycles;
    do_start(2'b11, 8'h01);
    feed(8'h00);
    feed(8'h40);
    start = 1'b1; mode = 2'b00; index_in = 8'hFF;
    db_valid = 1'b1; db_in = 8'h55;
    tick();
    n_checks++; if ({ea_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL fix_cycle: got %b expected 01", {ea_valid, busy}); end
    tick();
    start = 1'b0; db_valid = 1'b0;
    n_checks++; if (ea_valid !== 1'b1) begin n_fail++; $display("FAIL fix_valid: got %b expected 1", ea_valid); end
    n_checks++; if (ea !== 16'h4001) begin n_fail++; $display("FAIL fix_ea: got %h expected 4001", ea); end
    n_checks++; if (page_cross !== 1'b0) begin n_fail++; $display("FAIL fix_pc: got %b expected 0", page_cross); end
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy === 1'b1 || ea_valid === 1'b1) busy_cycles++;
    end
    n_checks++; if (busy_cycles !== 0) begin n_fail++; $display("FAIL fix_no_second_op: got %0d active cycles expected 0", busy_cycles); end
    n_checks++; if (ea !== 16'h4001) begin n_fail++; $display("FAIL fix_hold: got %h expected 4001", ea); end
  endtask

  initial begin
    test_reset();
    test_abs_no_cross();
    test_abs_cross();
    test_zp_wrap();
    test_ind_y();
    test_forced_fix();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/index_address_unit.md
Name: index_address_unit

Overview:
- Effective-address generator that consumes the index register value (Y or X address_out) and adds it to an operand base for indexed addressing.
- Sequences operand and pointer bytes off the data bus for the 65C02 modes abs,Y, zp,Y and (zp),Y, and inserts the page-cross fix-up cycle.
- Sits between the index registers and the address bus mux; it is the reader side of the index register's address output.

Parameters:
ZP_PAGE, 8'h00, high byte used for zero-page operand and pointer addresses.

Ports:
fclk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a calculation; sampled only in IDLE
mode  input  2  00 abs,Y; 01 zp,Y; 10 (zp),Y; 11 abs,Y with forced fix cycle (store/RMW)
index_in  input  8  index register value; latched on accepted start
db_in  input  8  operand or pointer byte from the data bus
db_valid  input  1  db_in holds the byte the unit is waiting for
mem_rd  output  1  unit requests a pointer read at mem_addr
mem_addr  output  16  pointer fetch address, valid while mem_rd=1
busy  output  1  high in every state except IDLE
ea  output  16  effective address, held from DONE until the next accepted start
ea_valid  output  1  one-cycle pulse when ea is final
page_cross  output  1  carry out of low-byte add for the current result; held with ea

Behaviour:
- Reset is synchronous, active-high, and has priority over every other input.
  - State goes to IDLE.
  - ea=16'h0000, ea_valid=0, page_cross=0, busy=0, mem_rd=0, mem_addr=16'h0000.
  - Reset mid-operation abandons the calculation; no ea_valid is produced.
- States: IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, ADD, FIX, DONE.
- IDLE:
  - On start, latch mode and index_in, clear page_cross, go to OP_LO.
  - start while busy is ignored.
- OP_LO: wait for db_valid, then latch the low byte (or the zp/pointer byte).
  - Modes 00/11 go to OP_HI.
  - Mode 01 goes to ADD with base={ZP_PAGE, byte}.
  - Mode 10 goes to PTR_LO.
- OP_HI: on db_valid, latch the high byte, go to ADD.
- PTR_LO:
  - mem_rd=1, mem_addr={ZP_PAGE, zp}.
  - On db_valid, latch base low byte, go to PTR_HI.
- PTR_HI:
  - mem_rd=1, mem_addr={ZP_PAGE, zp+1 mod 256}. The pointer wraps within the page: zp=FF reads FF then 00.
  - On db_valid, latch base high byte, go to ADD.
- db_valid outside OP_LO/OP_HI/PTR_LO/PTR_HI is ignored. States wait indefinitely without db_valid.
- ADD:
  - Compute {c, lo} = base_lo + index (9-bit).
  - Mode 01: ea={ZP_PAGE, lo} (wraps in page), page_cross=0, go to DONE.
  - Other modes: ea={base_hi, lo}, page_cross=c. If c=1 or mode=11, go to FIX; otherwise go to DONE.
- FIX:
  - ea_hi = base_hi + c, modulo 256. FFxx+carry wraps to 00xx.
  - Go to DONE.
- DONE: ea_valid=1 for exactly one cycle, then go to IDLE. busy is low in the cycle after DONE.
- Latency, counted from the cycle the last needed byte is accepted:
  - ea_valid is 2 cycles later without FIX.
  - ea_valid is 3 cycles later with FIX.
- Between ADD and DONE, ea is a don't-care internally. Externally, only values qualified by ea_valid, or held after it, are defined.
- ea and page_cross hold until the next accepted start.

Test Plan:
- Reset: assert reset 2 cycles mid-OP_HI -> busy=0, ea=0000, no ea_valid. A new start then proceeds normally.
- abs,Y, no cross: mode=00, index=05, bytes 10,20 -> ea=2015, page_cross=0, ea_valid 2 cycles after the 2nd byte.
- abs,Y, cross and wrap:
  - mode=00, index=10, bytes F8,12 -> ea=1308, page_cross=1, ea_valid 3 cycles after the byte.
  - Bytes F8,FF -> ea=0008.
- zp,Y wrap: mode=01, index=20, byte F0 -> ea=0010, page_cross=0.
- (zp),Y, pointer wrap:
  - mode=10, index=01, byte FF -> mem_addr 00FF, then 0000.
  - Supply FF,30 -> ea=3100, page_cross=1.
- Forced fix and ignore rules:
  - mode=11, index=01, bytes 00,40 -> ea=4001, page_cross=0, FIX cycle taken.
  - start and db_valid pulsed during ADD/FIX do not alter the result or launch a second op.
